// File: rtl/apb_mem_bridge_pkg.sv
// Shared types for the APB-to-memory bridge: FSM states and error causes.
// Imported by the region decoder and the bridge top.
package apb_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_RO,
    ERR_TIMEOUT
  } err_cause_t;

endpackage

// File: rtl/apb_region_dec.sv
// Combinational address decoder: range, alignment and read-only checks,
// one-hot region select and region-local byte address.
module apb_region_dec
  import apb_mem_bridge_pkg::*;
#(
  parameter int                     ADDR_W        = 32,
  parameter int                     DATA_W        = 64,
  parameter int                     NUM_REGIONS   = 2,
  parameter int                     REGION_SIZE_K = 64,
  parameter logic [ADDR_W-1:0]      BASE_ADDR     = '0,
  parameter logic [NUM_REGIONS-1:0] RO_MASK       = '0
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   write,
  output logic [NUM_REGIONS-1:0] region_oh,
  output logic [ADDR_W-1:0]      local_addr,
  output err_cause_t             cause
);

  localparam int                REGION_LSB = $clog2(REGION_SIZE_K * 1024);
  localparam int                ALIGN_LSB  = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LOCAL_MASK = ADDR_W'((64'd1 << REGION_LSB) - 64'd1);

  logic [ADDR_W-1:0]      offset;
  logic [ADDR_W-1:0]      region_num;
  logic [NUM_REGIONS-1:0] hit;
  logic                   in_range;
  logic                   aligned;
  logic                   ro_hit;

  // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    offset     = addr - BASE_ADDR;
    region_num = offset >> REGION_LSB;
    in_range   = (addr >= BASE_ADDR) && (region_num < ADDR_W'(NUM_REGIONS));
    hit        = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = in_range && (region_num == ADDR_W'(i));
    end
    aligned    = (addr[ALIGN_LSB-1:0] == '0);
    ro_hit     = write && |(hit & RO_MASK);
    local_addr = offset & LOCAL_MASK;
    region_oh  = '0;
    cause      = ERR_NONE;
    // Range takes precedence over alignment, which takes precedence over RO.
    if (!in_range) begin
      cause = ERR_RANGE;
    end else if (!aligned) begin
      cause = ERR_ALIGN;
    end else if (ro_hit) begin
      cause = ERR_RO;
    end else begin
      region_oh = hit;
    end
  end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB slave bridging single transfers onto per-region memory ports, with
// decode/timeout error reporting and a saturating PSLVERR counter.
module apb_mem_bridge
  import apb_mem_bridge_pkg::*;
#(
  parameter int                     ADDR_W        = 32,
  parameter int                     DATA_W        = 64,
  parameter int                     NUM_REGIONS   = 2,
  parameter int                     REGION_SIZE_K = 64,
  parameter logic [ADDR_W-1:0]      BASE_ADDR     = '0,
  parameter logic [NUM_REGIONS-1:0] RO_MASK       = '0,
  parameter int                     TIMEOUT       = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSELx,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_W-1:0]             PADDR,
  input  logic [DATA_W-1:0]             PWDATA,
  input  logic [DATA_W/8-1:0]           PSTRB,
  output logic [DATA_W-1:0]             PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGIONS-1:0]        mem_req_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_wstrb_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata_i,
  input  logic [NUM_REGIONS-1:0]        mem_rvalid_i,
  output logic [15:0]                   err_cnt_o
);

  localparam int STRB_W = DATA_W / 8;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q;
  logic                   write_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [STRB_W-1:0]      strb_q;
  logic [NUM_REGIONS-1:0] region_q;
  err_cause_t             cause_q;
  logic [7:0]             wait_cnt_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [15:0]            err_cnt_q;

  logic [NUM_REGIONS-1:0] dec_region;
  logic [ADDR_W-1:0]      dec_local;
  err_cause_t             dec_cause;

  logic                   setup;
  logic                   err_flag;
  logic                   rvalid_sel;
  logic                   timeout_hit;
  logic                   req_fire;
  logic [DATA_W-1:0]      sel_rdata;

  apb_region_dec #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .NUM_REGIONS  (NUM_REGIONS),
    .REGION_SIZE_K(REGION_SIZE_K),
    .BASE_ADDR    (BASE_ADDR),
    .RO_MASK      (RO_MASK)
  ) u_dec (
    .addr      (PADDR),
    .write     (PWRITE),
    .region_oh (dec_region),
    .local_addr(dec_local),
    .cause     (dec_cause)
  );

  assign setup       = PSELx && !PENABLE;
  assign err_flag    = (cause_q != ERR_NONE);
  assign rvalid_sel  = |(mem_rvalid_i & region_q);
  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));
  // A dropped PSELx in REQ cancels the access before it reaches memory.
  assign req_fire    = (state_q == REQ) && PSELx && !err_flag;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_q[i]) sel_rdata = sel_rdata | mem_rdata_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    PREADY      = (state_q == RESP);
    PSLVERR     = (state_q == RESP) && err_flag;
    PRDATA      = ((state_q == RESP) && !err_flag && !write_q) ? rdata_q : '0;
    mem_req_o   = req_fire ? region_q : '0;
    mem_addr_o  = req_fire ? addr_q   : '0;
    mem_we_o    = req_fire && write_q;
    mem_wdata_o = req_fire ? wdata_q  : '0;
    mem_wstrb_o = req_fire ? strb_q   : '0;
    case (state_q)
      IDLE: if (setup) state_d = REQ;
      REQ: begin
        if (!PSELx)                    state_d = IDLE;
        else if (err_flag || write_q)  state_d = RESP;
        else                           state_d = WAIT;
      end
      // rvalid is tested before the timeout so a same-cycle response wins.
      WAIT: begin
        if (!PSELx)                        state_d = IDLE;
        else if (rvalid_sel || timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      region_q   <= '0;
      cause_q    <= ERR_NONE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (setup) begin
          addr_q     <= dec_local;
          write_q    <= PWRITE;
          wdata_q    <= PWDATA;
          strb_q     <= PSTRB;
          region_q   <= dec_region;
          cause_q    <= dec_cause;
          wait_cnt_q <= '0;
          rdata_q    <= '0;
        end
        WAIT: if (PSELx) begin
          if (rvalid_sel)       rdata_q    <= sel_rdata;
          else if (timeout_hit) cause_q    <= ERR_TIMEOUT;
          else                  wait_cnt_q <= wait_cnt_q + 8'd1;
        end
        RESP: if (err_flag && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench for apb_mem_bridge: directed scenarios plus randomized
// transfers scored against an arithmetic model of decode, latency and errors.
module tb_apb_mem_bridge;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 64;
  localparam int          NR      = 2;
  localparam int          RSK     = 4;
  localparam int          RBYTES  = RSK * 1024;
  localparam int          TO      = 8;
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [1:0]  RO      = 2'b10;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic                 PSELx, PENABLE, PWRITE;
  logic [ADDR_W-1:0]    PADDR;
  logic [DATA_W-1:0]    PWDATA;
  logic [7:0]           PSTRB;
  logic [DATA_W-1:0]    PRDATA;
  logic                 PREADY, PSLVERR;
  logic [NR-1:0]        mem_req_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_we_o;
  logic [DATA_W-1:0]    mem_wdata_o;
  logic [7:0]           mem_wstrb_o;
  logic [NR*DATA_W-1:0] mem_rdata_i;
  logic [NR-1:0]        mem_rvalid_i;
  logic [15:0]          err_cnt_o;

  int n_pass = 0;
  int n_total = 0;
  int exp_err_cnt = 0;

  apb_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGIONS(NR), .REGION_SIZE_K(RSK),
    .BASE_ADDR(BASE), .RO_MASK(RO), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .err_cnt_o(err_cnt_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the address map, written as plain arithmetic.
  task automatic model_decode(input logic [31:0] addr, input logic wr,
                              output bit err, output int region, output logic [31:0] loc);
    longint off;
    off    = longint'(addr) - longint'(BASE);
    err    = 1'b0;
    region = 0;
    loc    = '0;
    if (off < 0 || off >= longint'(NR * RBYTES)) begin
      err = 1'b1;
    end else begin
      region = int'(off / RBYTES);
      loc    = 32'(off % RBYTES);
      if (addr % 8 != 0) err = 1'b1;
      if (wr && RO[region]) err = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".PREADY"},  64'(PREADY), 64'd0);
    check({tag, ".PSLVERR"}, 64'(PSLVERR), 64'd0);
    check({tag, ".PRDATA"},  PRDATA, 64'd0);
    check({tag, ".req"},     64'(mem_req_o), 64'd0);
    check({tag, ".addr"},    64'(mem_addr_o), 64'd0);
    check({tag, ".we"},      64'(mem_we_o), 64'd0);
    check({tag, ".wdata"},   mem_wdata_o, 64'd0);
    check({tag, ".wstrb"},   64'(mem_wstrb_o), 64'd0);
    check({tag, ".err_cnt"}, 64'(err_cnt_o), 64'd0);
  endtask

  // One APB transfer. d = cycles from the memory request to the selected
  // region's rvalid (outside 1..TO means no useful response). noise adds
  // other-region rvalids and an early own-region rvalid in the REQ cycle.
  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [63:0] wdata, input logic [7:0] strb, input int d,
                         input logic [63:0] rdata, input bit noise);
    bit          err;
    int          region;
    logic [31:0] loc;
    int          exp_lat;
    bit          exp_slv;
    logic [63:0] exp_prdata;
    int          lat = -1;
    int          req_cnt = 0;
    logic [1:0]  req_val = '0;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strb = '0;
    logic        slv = 1'b0;
    logic [63:0] prd = '0;
    bit          leak = 1'b0;

    model_decode(addr, wr, err, region, loc);
    if (err || wr) begin
      exp_lat = 2; exp_slv = err; exp_prdata = '0;
    end else if (d >= 1 && d <= TO) begin
      exp_lat = d + 2; exp_slv = 1'b0; exp_prdata = rdata;
    end else begin
      exp_lat = TO + 2; exp_slv = 1'b1; exp_prdata = '0;
    end
    if (exp_slv && exp_err_cnt < 65535) exp_err_cnt++;

    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata; PSTRB = strb;
    mem_rvalid_i = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge PCLK);
      if (mem_req_o != '0) begin
        req_cnt++; req_val = mem_req_o; req_addr = mem_addr_o; req_we = mem_we_o;
        req_wdata = mem_wdata_o; req_strb = mem_wstrb_o;
      end
      if (PREADY) begin
        lat = k; slv = PSLVERR; prd = PRDATA;
      end else if (PRDATA != '0) begin
        leak = 1'b1;
      end
      PENABLE      = 1'b1;
      mem_rvalid_i = '0;
      mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
      if (!err && !wr && k == 1 + d) begin
        mem_rvalid_i[region] = 1'b1;
        mem_rdata_i[region*64 +: 64] = rdata;
      end
      if (noise) begin
        mem_rvalid_i[1-region] = 1'($urandom_range(0, 1));
        if (k == 1 && d >= 2) mem_rvalid_i[region] = 1'b1;
      end
    end
    @(negedge PCLK);
    check({tag, ".ready_one_cycle"}, 64'(PREADY), 64'd0);
    PSELx = 1'b0; PENABLE = 1'b0; mem_rvalid_i = '0;

    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".pslverr"}, 64'(slv), 64'(exp_slv));
    check({tag, ".prdata"},  prd, exp_prdata);
    check({tag, ".prdata_idle_zero"}, 64'(leak), 64'd0);
    check({tag, ".req_cycles"}, 64'(req_cnt), err ? 64'd0 : 64'd1);
    if (!err) begin
      check({tag, ".req_onehot"}, 64'(req_val), 64'd1 << region);
      check({tag, ".mem_addr"},   64'(req_addr), 64'(loc));
      check({tag, ".mem_we"},     64'(req_we), 64'(wr));
      if (wr) begin
        check({tag, ".mem_wdata"}, req_wdata, wdata);
        check({tag, ".mem_wstrb"}, 64'(req_strb), 64'(strb));
      end
    end
    check({tag, ".err_cnt"}, 64'(err_cnt_o), 64'(exp_err_cnt));
  endtask

  // Start a read and drop PSELx in cycle k_abort; no response may follow.
  task automatic do_abort(input string tag, input logic [31:0] addr, input int k_abort);
    int ready_seen = 0;
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0;
    for (int k = 1; k <= k_abort; k++) begin
      @(negedge PCLK);
      if (PREADY) ready_seen++;
      PENABLE = 1'b1;
    end
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (TO + 4) begin
      @(negedge PCLK);
      if (PREADY) ready_seen++;
    end
    check({tag, ".no_pready"}, 64'(ready_seen), 64'd0);
    check({tag, ".err_cnt"},   64'(err_cnt_o), 64'(exp_err_cnt));
  endtask

  initial begin
    logic [31:0] a;
    logic        wr;
    int          kind;

    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; mem_rdata_i = '0; mem_rvalid_i = '0;
    repeat (3) @(negedge PCLK);
    check_outputs_zero("reset");
    PRESETn = 1'b1;

    do_xfer("wr_r0", 32'h1000_0008, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, '0, 1'b0);
    do_xfer("rd_r1", 32'h1000_1010, 1'b0, '0, '0, 3, 64'h1234, 1'b0);
    do_xfer("wr_ro", 32'h1000_1000, 1'b1, 64'h55, 8'h0F, 0, '0, 1'b0);
    do_xfer("rd_range", 32'h1000_2000, 1'b0, '0, '0, 1, 64'hFFFF, 1'b1);
    do_xfer("rd_align", 32'h1000_0004, 1'b0, '0, '0, 1, 64'hFFFF, 1'b1);
    do_xfer("rd_below", 32'h0FFF_FFF8, 1'b0, '0, '0, 1, 64'h1, 1'b0);
    do_xfer("rd_timeout", 32'h1000_0000, 1'b0, '0, '0, -1, '0, 1'b0);

    // A late rvalid two cycles after the timed-out response must be ignored.
    @(negedge PCLK);
    mem_rvalid_i = 2'b01; mem_rdata_i[63:0] = 64'hBAD0_BAD0;
    @(negedge PCLK);
    mem_rvalid_i = '0;
    repeat (2) begin
      @(negedge PCLK);
      check("late_rvalid.PREADY", 64'(PREADY), 64'd0);
      check("late_rvalid.PRDATA", PRDATA, 64'd0);
    end
    check("late_rvalid.err_cnt", 64'(err_cnt_o), 64'(exp_err_cnt));

    do_xfer("rd_last_wait", 32'h1000_1FF8, 1'b0, '0, '0, TO, 64'hA5A5_0000_1111_5A5A, 1'b1);
    do_xfer("rd_one_late",  32'h1000_0FF8, 1'b0, '0, '0, TO + 1, 64'h7777, 1'b0);
    do_xfer("rd_fast",      32'h1000_0FF8, 1'b0, '0, '0, 1, 64'h8888_0000_0000_0001, 1'b1);

    do_abort("abort_req_err", 32'h1000_0004, 1);
    do_abort("abort_wait",    32'h1000_0010, 3);
    do_xfer("after_abort", 32'h1000_0018, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h3C, 0, '0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 4));
      wr   = 1'($urandom_range(0, 1));
      case (kind)
        0, 1:    a = BASE + 32'(8 * $urandom_range(0, 2 * RBYTES / 8 - 1));
        2:       a = BASE + 32'(8 * $urandom_range(0, 2 * RBYTES / 8 - 1)) + 32'($urandom_range(1, 7));
        3:       a = ($urandom_range(0, 1) == 1) ? BASE + 32'(2 * RBYTES) + 32'(8 * $urandom_range(0, 1000))
                                                 : BASE - 32'(8 * $urandom_range(1, 1000));
        default: a = BASE + 32'(RBYTES) + 32'(8 * $urandom_range(0, RBYTES / 8 - 1));
      endcase
      do_xfer($sformatf("rnd%0d", t), a, wr, {$urandom, $urandom}, 8'($urandom),
              int'($urandom_range(1, TO + 2)), {$urandom, $urandom}, 1'b1);
    end

    // Reset in the middle of a read wait, then a normal write.
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h1000_0010; PWRITE = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
    end
    PRESETn = 1'b0;
    #1;
    check_outputs_zero("mid_wait_reset");
    exp_err_cnt = 0;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    do_xfer("post_reset_wr", 32'h1000_0020, 1'b1, 64'hFEED_FACE_0BAD_F00D, 8'hF0, 0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
